// File: rtl/return_address_stack.sv
// return_address_stack: circular-buffer return address stack with checkpoint restore
module return_address_stack #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_SIZE = 16,
  parameter int PTR_WIDTH = $clog2(RAS_SIZE),
  parameter int CNT_WIDTH = $clog2(RAS_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bp_ras_addr,
  input  logic                  bp_ras_push,
  input  logic                  bp_ras_pop,
  output logic [ADDR_WIDTH-1:0] ras_bp_addr,
  output logic [PTR_WIDTH-1:0]  ras_cp_wptr,
  output logic [CNT_WIDTH-1:0]  ras_cp_count,
  input  logic                  exbru_ras_restore_valid,
  input  logic [PTR_WIDTH-1:0]  exbru_ras_restore_wptr,
  input  logic [CNT_WIDTH-1:0]  exbru_ras_restore_count
);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(RAS_SIZE);
  logic [ADDR_WIDTH-1:0] entry [RAS_SIZE];
  logic [PTR_WIDTH-1:0] wptr, top_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic empty;
  always_comb begin
    top_ptr = wptr - PTR_WIDTH'(1);
    empty = count == '0;
    ras_bp_addr = empty ? '0 : entry[top_ptr];
    ras_cp_wptr = wptr;
    ras_cp_count = count;
  end
  // pop never clears entries, so a restore can re-expose older return addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      count <= '0;
      for (int i = 0; i < RAS_SIZE; i++) entry[i] <= '0;
    end else if (exbru_ras_restore_valid) begin
      wptr <= exbru_ras_restore_wptr;
      count <= exbru_ras_restore_count > FULL ? FULL : exbru_ras_restore_count;
    end else if (bp_ras_push && bp_ras_pop && !empty) begin
      entry[top_ptr] <= bp_ras_addr;
    end else if (bp_ras_push) begin
      entry[wptr] <= bp_ras_addr;
      wptr <= wptr + PTR_WIDTH'(1);
      if (count != FULL) count <= count + CNT_WIDTH'(1);
    end else if (bp_ras_pop && !empty) begin
      wptr <= top_ptr;
      count <= count - CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: directed and random checks against a stack model
module tb_return_address_stack;
  localparam int N = 16;
  logic clk = 0, rst = 0, push = 0, pop = 0, rv = 0;
  logic [31:0] addr = 0;
  logic [3:0] rw = 0;
  logic [4:0] rc = 0;
  logic [31:0] top;
  logic [3:0] wptr;
  logic [4:0] count;
  int errors = 0, checks = 0;
  int mem [N];
  int wp = 0, cnt = 0;
  bit live = 0;

  return_address_stack dut (
    .clk(clk), .rst(rst), .bp_ras_addr(addr), .bp_ras_push(push), .bp_ras_pop(pop),
    .ras_bp_addr(top), .ras_cp_wptr(wptr), .ras_cp_count(count),
    .exbru_ras_restore_valid(rv), .exbru_ras_restore_wptr(rw), .exbru_ras_restore_count(rc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_top();
    return cnt > 0 ? 32'(mem[(wp + N - 1) % N]) : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (mem[i]) mem[i] = 0;
      wp = 0;
      cnt = 0;
      live = 1;
    end else if (rv) begin
      wp = int'(rw);
      cnt = int'(rc) > N ? N : int'(rc);
    end else if (push && pop && cnt > 0) begin
      mem[(wp + N - 1) % N] = int'(addr);
    end else if (push) begin
      mem[wp] = int'(addr);
      wp = (wp + 1) % N;
      if (cnt < N) cnt++;
    end else if (pop && cnt > 0) begin
      wp = (wp + N - 1) % N;
      cnt--;
    end
  end

  always @(negedge clk) if (live) begin
    chk("model_top", top, model_top());
    chk("model_wptr", 32'(wptr), 32'(wp));
    chk("model_count", 32'(count), 32'(cnt));
  end

  task automatic cyc(input bit r, input bit pu, input bit po, input logic [31:0] a,
                     input bit v = 0, input logic [3:0] w = 0, input logic [4:0] c = 0);
    rst = r; push = pu; pop = po; addr = a; rv = v; rw = w; rc = c;
    @(posedge clk);
    #1;
    rst = 0; push = 0; pop = 0; rv = 0;
  endtask

  task automatic lit(input string nm, input logic [31:0] t, input int w, input int c);
    chk({nm, "_top"}, top, t);
    if (w >= 0) chk({nm, "_wptr"}, 32'(wptr), 32'(w));
    chk({nm, "_count"}, 32'(count), 32'(c));
  endtask

  initial begin
    cyc(1, 1, 0, 32'hdead);
    cyc(0, 0, 0, 0);
    lit("reset", 0, 0, 0);
    cyc(0, 0, 1, 0);
    lit("pop_empty", 0, 0, 0);
    cyc(0, 1, 0, 32'h80100024);
    cyc(0, 1, 0, 32'h80100104);
    lit("push2", 32'h80100104, 2, 2);
    cyc(0, 0, 1, 0);
    lit("pop1", 32'h80100024, 1, 1);
    cyc(0, 0, 1, 0);
    lit("pop2", 0, 0, 0);
    cyc(0, 1, 0, 32'h80100024);
    cyc(0, 1, 1, 32'h80aabbc0);
    lit("replace", 32'h80aabbc0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 32'h1000);
    lit("replace_empty", 32'h1000, 1, 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 17; i++) cyc(0, 1, 0, 32'h100 + 4 * i);
    lit("overflow", 32'h140, 1, 16);
    for (int k = 0; k < 16; k++) begin
      chk("drain_top", top, 32'h140 - 4 * k);
      cyc(0, 0, 1, 0);
    end
    lit("drained", 0, -1, 0);
    cyc(0, 0, 1, 0);
    lit("underflow", 0, -1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 32'h2000);
    cyc(0, 1, 0, 32'h2004);
    lit("cp", 32'h2004, 2, 2);
    cyc(0, 1, 0, 32'h2008);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 2, 2);
    lit("restore", 32'h2004, 2, 2);
    cyc(0, 1, 0, 32'h3000, 1, 2, 2);
    lit("restore_push", 32'h2004, 2, 2);
    cyc(0, 0, 0, 0, 1, 3, 31);
    lit("restore_clamp", 32'h2008, 3, 16);
    cyc(1, 1, 0, 32'h4444);
    lit("rst_mid", 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom,
          r > 0 && r < 5, 4'($urandom), 5'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Return address stack (RAS) serving the branch predictor.
- Receives bp_ras_push/bp_ras_pop/bp_ras_addr from the predictor in the fetch stage and supplies the predicted return target on ras_bp_addr.
- Implemented as a circular buffer; the oldest entry is overwritten on overflow.
- Exports its pointer state for checkpointing and accepts a restore from the branch unit on misprediction.

Parameters:
- ADDR_WIDTH, 32, width of stored return addresses.
- RAS_SIZE, 16, number of entries (power of two, >= 2).
- PTR_WIDTH, $clog2(RAS_SIZE), write-pointer width.
- CNT_WIDTH, $clog2(RAS_SIZE+1), occupancy-count width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- bp_ras_addr  input  ADDR_WIDTH  return address to push (call PC+4).
- bp_ras_push  input  1  push request, sampled at posedge.
- bp_ras_pop  input  1  pop request, sampled at posedge.
- ras_bp_addr  output  ADDR_WIDTH  current top-of-stack prediction.
- ras_cp_wptr  output  PTR_WIDTH  current write pointer, for checkpoint.
- ras_cp_count  output  CNT_WIDTH  current occupancy, for checkpoint.
- exbru_ras_restore_valid  input  1  restore request from branch unit.
- exbru_ras_restore_wptr  input  PTR_WIDTH  pointer to restore.
- exbru_ras_restore_count  input  CNT_WIDTH  count to restore.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): on a posedge with rst=1, all entries, wptr and count are set to 0. The rst-cycle inputs are ignored.
- Reset outputs: ras_bp_addr=0, ras_cp_wptr=0, ras_cp_count=0.
- State: entry[0..RAS_SIZE-1], wptr (next free slot), count (0..RAS_SIZE).
- ras_bp_addr is combinational from registered state only: entry[wptr-1 mod RAS_SIZE] when count>0, else 0. Push/pop inputs in the current cycle do not affect it; the predictor consumes it in the same cycle it asserts pop.
- Updates take effect at the posedge, with this priority: rst > restore > push/pop.
- Restore: wptr<=restore_wptr, count<=restore_count. Entries are unchanged. Push/pop in the same cycle are dropped. A restore_count > RAS_SIZE is clamped to RAS_SIZE.
- Push only: entry[wptr]<=bp_ras_addr; wptr<=wptr+1 (wraps at RAS_SIZE); count<=min(count+1, RAS_SIZE).
- Overflow: when count==RAS_SIZE, a push overwrites the oldest entry (at wptr). count stays RAS_SIZE.
- Pop only: if count>0, wptr<=wptr-1 (wraps 0->RAS_SIZE-1) and count<=count-1. If count==0, no state change (underflow ignored).
- Push and pop together (coroutine/context-switch jalr): replace top.
  - If count>0: entry[wptr-1]<=bp_ras_addr; wptr and count are unchanged.
  - If count==0: treated as push only.
- Neither asserted: hold.
- Entries are never cleared by pop; only count/wptr define validity.
- No stall or backpressure: every request completes in one cycle.

Test Plan:
- Reset then idle -> ras_bp_addr=0, ras_cp_wptr=0, ras_cp_count=0; pop on empty -> state unchanged, ras_bp_addr stays 0.
- Push 0x80100024, push 0x80100104 -> ras_bp_addr=0x80100104, count=2. Pop -> ras_bp_addr=0x80100024, count=1. Pop -> ras_bp_addr=0, count=0.
- Push 0x80100024, then push+pop with 0x80aabbc0 in one cycle -> ras_bp_addr=0x80aabbc0, count=1, wptr=1. Push+pop on empty stack with 0x1000 -> count=1, top=0x1000.
- Push 17 addresses 0x100+4*i (i=0..16) with RAS_SIZE=16 -> count=16, wptr=1, top=0x140. 16 pops return 0x140 down to 0x104. The 17th pop is ignored, count=0.
- Push A=0x2000, B=0x2004; capture cp (wptr=2, count=2); push C=0x2008, pop, pop; restore to cp -> ras_bp_addr=0x2004, count=2.
- Restore asserted with push=1 of 0x3000 in the same cycle -> push dropped, state equals restore values. rst asserted mid-sequence with push -> all outputs 0 next cycle.
